// File: rtl/uart_rx_fifo.sv
// Receive FIFO sitting between a UART receiver and its consumer, with a sticky overflow flag.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads; the default is a registered read port.
module uart_rx_fifo #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [DBIT-1:0]       rx_dout,
  input  logic                  rd,
  input  logic                  clr_overflow,
  output logic [DBIT-1:0]       r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DBIT-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  drop;
  logic [ADDR_WIDTH:0]   count_nxt;

  function automatic logic [ADDR_WIDTH:0] next_count(input logic [ADDR_WIDTH:0] cur,
                                                     input logic wr_ok, input logic rd_ok);
    logic [ADDR_WIDTH:0] res;
    res = cur;
    if (wr_ok && !rd_ok)
      res = cur + 1'b1;
    else if (rd_ok && !wr_ok)
      res = cur - 1'b1;
    return res;
  endfunction

  // A write into a full FIFO is still accepted when a pop frees the slot in the same edge.
  assign rd_acc    = rd & ~empty;
  assign wr_acc    = rx_done_tick & (~full | rd);
  assign drop      = rx_done_tick & full & ~rd;
  assign count_nxt = next_count(count, wr_acc, rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr] <= rx_dout;
  end

  // Flags are derived from the next count so they are registered yet always agree with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Masked while empty so stale words left behind by a reset never appear on r_data.
  assign r_data = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (reset)
      r_data <= '0;
    else if (rd_acc)
      r_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, giving the data word width and matching the receiver's rx_dout width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, giving a depth of 2**ADDR_WIDTH words (16 by default).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx_done_tick, input, 1 bit: one-cycle write strobe from the receiver.
REQ-006 The module SHALL have port rx_dout, input, DBIT bits: received byte, valid while rx_done_tick=1.
REQ-007 The module SHALL have port rd, input, 1 bit: read/pop request from the consumer.
REQ-008 The module SHALL have port clr_overflow, input, 1 bit: clears the sticky overflow flag.
REQ-009 The module SHALL have port r_data, output, DBIT bits: read data.
REQ-010 The module SHALL have port empty, output, 1 bit: high when the FIFO holds no words.
REQ-011 The module SHALL have port full, output, 1 bit: high when it holds 2**ADDR_WIDTH words.
REQ-012 The module SHALL have port count, output, ADDR_WIDTH+1 bits: number of stored words, 0 to 2**ADDR_WIDTH.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag, high after a write was dropped.

Function
REQ-014 A write SHALL be accepted when rx_done_tick=1 and (full=0 or rd=1); the word is stored at wr_ptr and wr_ptr advances.
REQ-015 A read SHALL be accepted when rd=1 and empty=0; rd_ptr advances.
REQ-016 Pointers SHALL be ADDR_WIDTH bits and wrap from 2**ADDR_WIDTH-1 to 0 with no gap.
REQ-017 count SHALL be +1 on an accepted write only, -1 on an accepted read only, and unchanged when both or neither are accepted.
REQ-018 empty, full and count SHALL be registered and consistent in the same cycle: empty=(count==0), full=(count==2**ADDR_WIDTH).
REQ-019 When full with rd=1 and rx_done_tick=1, both operations SHALL occur, count SHALL stay at 2**ADDR_WIDTH, and overflow SHALL not be set.
REQ-020 When empty with rd=1 and rx_done_tick=1, the read SHALL be ignored, the write accepted, and count SHALL become 1.
REQ-021 rx_done_tick=1 with full=1 and rd=0 SHALL drop the word, leave pointers and count unchanged, and set overflow on the next edge.
REQ-022 rd=1 with empty=1 SHALL be ignored: no pointer change, r_data held, no error flag.
REQ-023 overflow SHALL stay high until clr_overflow=1; if clr_overflow and a new drop occur in the same cycle, overflow SHALL remain 1.
REQ-024 The FIFO SHALL preserve write order; there SHALL be no combinational path from rd to full or empty.

Reset
REQ-025 While reset=1 at a rising edge, wr_ptr, rd_ptr and count SHALL become 0, with empty=1, full=0, overflow=0 and r_data=0.
REQ-026 Reset SHALL take priority over rx_done_tick, rd and clr_overflow in the same cycle.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; memory contents SHALL not be cleared and SHALL not be observable afterwards.

Configuration
REQ-028 Macro UART_RX_FIFO_FWFT_EN SHALL select the read mode.
REQ-029 Without UART_RX_FIFO_FWFT_EN, r_data SHALL be registered: it is loaded with mem[rd_ptr] on the edge that accepts a read and otherwise held, giving one-cycle read latency.
REQ-030 With UART_RX_FIFO_FWFT_EN, r_data SHALL continuously show mem[rd_ptr] (first-word fall-through); it is valid whenever empty=0, and rd pops that word.

Verification
REQ-031 After reset, a single write of rx_dout=8'hA5 SHALL give count=1 and empty=0; rd then yields r_data=8'hA5 (FWFT: before the rd; registered: the cycle after the rd), followed by empty=1.
REQ-032 Writing 8'h00..8'h0F (16 writes) SHALL give full=1 and count=16; a 17th write of 8'hFF SHALL set overflow=1, and 16 reads SHALL return 8'h00..8'h0F in order.
REQ-033 From full, simultaneous rd and write of 8'h55 SHALL keep count=16 and overflow=0; 8'h55 SHALL be the last word read out.
REQ-034 From empty, simultaneous rd and write of 8'h3C SHALL give count=1, and the next read SHALL return 8'h3C.
REQ-035 Performing 40 write/read pairs (pointer wrap) SHALL return data in order; rd while empty SHALL leave r_data and count=0 unchanged.
REQ-036 Reset asserted with count=5 and overflow=1 SHALL give count=0, empty=1 and overflow=0 on the next edge; clr_overflow alone SHALL clear overflow.
